bean_datapath: RTL and testbench

BEAN_DATAPATH -- requirements
Module: bean_datapath

---
 rtl/bean_pkg.sv | 56 +++++
 rtl/bean_lfsr.sv | 23 ++
 rtl/bean_datapath.sv | 136 +++++++++++++
 tb/tb_bean_datapath.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bean_pkg.sv
// Shared constants and helpers for the bean datapath.
// Grid geometry, encodings, start state and the neighbour-cell helper.
package bean_pkg;

  localparam int GRID  = 8;
  localparam int CELLS = GRID * GRID;

  typedef enum logic [1:0] {
    DIR_R = 2'b00,
    DIR_L = 2'b01,
    DIR_U = 2'b10,
    DIR_D = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    HEAD_EMPTY = 2'b00,
    HEAD_BEAN  = 2'b10,
    HEAD_WALL  = 2'b11
  } head_e;

  // Border ring of the 8x8 grid, bit index y*8+x.
  localparam logic [63:0] WALL_MAP   = 64'hFF81_8181_8181_81FF;
  // Every interior cell except the start cell (1,1).
  localparam logic [63:0] INIT_BEANS = 64'h007E_7E7E_7E7E_7C00;
  localparam logic [5:0]  INIT_CNT   = 6'd35;

  localparam logic [2:0] START_X   = 3'd1;
  localparam logic [2:0] START_Y   = 3'd1;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef struct packed {
    logic       oob;
    logic [2:0] y;
    logic [2:0] x;
  } cell_t;

  // Neighbour of (x,y) along d; oob flags a step off the grid.
  function automatic cell_t next_cell(
    input logic [2:0] x,
    input logic [2:0] y,
    input logic [1:0] d
  );
    cell_t c;
    c.x   = x;
    c.y   = y;
    c.oob = 1'b0;
    case (d)
      DIR_R: begin c.x = x + 3'd1; c.oob = (x == 3'd7); end
      DIR_L: begin c.x = x - 3'd1; c.oob = (x == 3'd0); end
      DIR_U: begin c.y = y - 3'd1; c.oob = (y == 3'd0); end
      default: begin c.y = y + 3'd1; c.oob = (y == 3'd7); end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bean_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Loads seed on reset; a nonzero seed never reaches all-zero.
module bean_lfsr (
  input  logic       clk2,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic       fb;

  assign fb = q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3];
  assign q  = q_q;

  // Shift left, feedback into bit 0.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) q_q <= seed;
    else if (en) q_q <= {q_q[6:0], fb};
  end

endmodule

// File: rtl/bean_datapath.sv
// Bean-game datapath: player position, bean map, score and counts.
// Option: define RANDOM_GROWTH_EN to enable LFSR-driven bean regrowth.
module bean_datapath
  import bean_pkg::*;
(
  input  logic       clk2,
  input  logic       rst_n,
  input  logic       menu,
  input  logic       first_do,
  input  logic       go_one_step,
  input  logic       eat_apple,
  input  logic       random_growth,
  input  logic       null_out,
  input  logic       game_over,
  input  logic [1:0] dir,
  output logic [1:0] head,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y,
  output logic [7:0] score,
  output logic [5:0] bean_cnt,
  output logic       clear
);

  logic [2:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  dir_q, dir_d;
  logic [7:0]  score_q, score_d;
  logic [63:0] beans_q, beans_d;
  logic [5:0]  cnt_q, cnt_d;

  cell_t      look, mv;
  logic [5:0] look_idx, mv_idx;
  logic       grow_act;
  logic       grow_ok;
  logic [5:0] g_idx;

  assign look     = next_cell(x_q, y_q, dir);
  assign mv       = next_cell(x_q, y_q, dir_q);
  assign look_idx = {look.y, look.x};
  assign mv_idx   = {mv.y, mv.x};

`ifdef RANDOM_GROWTH_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  bean_lfsr u_lfsr (
    .clk2  (clk2),
    .rst_n (rst_n),
    .en    (1'b1),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[7:6];
  assign g_idx       = lfsr_q[5:0];
  assign grow_act    = random_growth;
  assign grow_ok     = !WALL_MAP[g_idx]
                     && (g_idx != {y_q, x_q})
                     && !beans_q[g_idx];
`else
  logic unused_rg;

  assign unused_rg = random_growth;
  assign g_idx     = 6'd0;
  assign grow_act  = 1'b0;
  assign grow_ok   = 1'b0;
`endif

  // Cell ahead along the live direction; off-grid counts as wall.
  always_comb begin
    head = HEAD_EMPTY;
    if (look.oob || WALL_MAP[look_idx]) head = HEAD_WALL;
    else if (beans_q[look_idx])         head = HEAD_BEAN;
  end

  // Strobe decode, highest priority first.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    score_d = score_q;
    beans_d = beans_q;
    cnt_d   = cnt_q;
    if (first_do) begin
      x_d     = START_X;
      y_d     = START_Y;
      dir_d   = DIR_R;
      score_d = 8'd0;
      beans_d = INIT_BEANS;
      cnt_d   = INIT_CNT;
    end else if (game_over || menu) begin
      x_d = x_q;
    end else if (eat_apple) begin
      x_d             = mv.x;
      y_d             = mv.y;
      beans_d[mv_idx] = 1'b0;
      if (score_q != 8'hFF) score_d = score_q + 8'd1;
      if (beans_q[mv_idx])  cnt_d   = cnt_q - 6'd1;
    end else if (null_out) begin
      x_d = mv.x;
      y_d = mv.y;
    end else if (grow_act) begin
      if (grow_ok) begin
        beans_d[g_idx] = 1'b1;
        cnt_d          = cnt_q + 6'd1;
      end
    end else if (go_one_step) begin
      dir_d = dir;
    end
  end

  // State registers with asynchronous reload of the start state.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= START_X;
      y_q     <= START_Y;
      dir_q   <= DIR_R;
      score_q <= 8'd0;
      beans_q <= INIT_BEANS;
      cnt_q   <= INIT_CNT;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      score_q <= score_d;
      beans_q <= beans_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pos_x    = x_q;
  assign pos_y    = y_q;
  assign score    = score_q;
  assign bean_cnt = cnt_q;
  assign clear    = (cnt_q == 6'd0);

endmodule

// File: tb/tb_bean_datapath.sv
// Scoreboard bench for bean_datapath against a grid-level game model.
// Driver pushes expected snapshots; a negedge monitor pops and compares.
module tb_bean_datapath;

  logic       clk2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       menu = 1'b0, first_do = 1'b0, go_one_step = 1'b0;
  logic       eat_apple = 1'b0, random_growth = 1'b0;
  logic       null_out = 1'b0, game_over = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [1:0] head;
  logic [2:0] pos_x, pos_y;
  logic [7:0] score;
  logic [5:0] bean_cnt;
  logic       clear;

  bean_datapath dut (
    .clk2          (clk2),
    .rst_n         (rst_n),
    .menu          (menu),
    .first_do      (first_do),
    .go_one_step   (go_one_step),
    .eat_apple     (eat_apple),
    .random_growth (random_growth),
    .null_out      (null_out),
    .game_over     (game_over),
    .dir           (dir),
    .head          (head),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .score         (score),
    .bean_cnt      (bean_cnt),
    .clear         (clear)
  );

  always #5 clk2 = ~clk2;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_FD   = 7'b1000000;
  localparam logic [6:0] S_GO_V = 7'b0100000;
  localparam logic [6:0] S_EAT  = 7'b0010000;
  localparam logic [6:0] S_NULL = 7'b0001000;
  localparam logic [6:0] S_RG   = 7'b0000100;
  localparam logic [6:0] S_STEP = 7'b0000010;
  localparam logic [6:0] S_MENU = 7'b0000001;

  typedef struct {
    int hd;
    int x;
    int y;
    int sc;
    int cnt;
    int clr;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    passes = 0;

  // Game model: coordinates, direction, score and a bean per cell.
  int         mx, my, mdir, mscore;
  bit         mb[64];
  logic [7:0] ml;

  function automatic bit is_wall(int x, int y);
    return (x <= 0) || (x >= 7) || (y <= 0) || (y >= 7);
  endfunction

  function automatic void step_of(int d, int x, int y,
                                  output int tx, output int ty);
    tx = x; ty = y;
    case (d)
      0: tx = x + 1;
      1: tx = x - 1;
      2: ty = y - 1;
      default: ty = y + 1;
    endcase
  endfunction

  function automatic int beans_left();
    int n = 0;
    for (int i = 0; i < 64; i++) if (mb[i]) n++;
    return n;
  endfunction

  // 3 wall, 2 bean, 0 empty
  function automatic int class_of(int d);
    int tx, ty;
    step_of(d, mx, my, tx, ty);
    if (is_wall(tx, ty)) return 3;
    if (mb[ty*8+tx]) return 2;
    return 0;
  endfunction

  function automatic void model_reload();
    mx = 1; my = 1; mdir = 0; mscore = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        mb[y*8+x] = !is_wall(x, y) && !(x == 1 && y == 1);
  endfunction

  function automatic void model_edge(logic [6:0] s, int d);
    int tx, ty;
    step_of(mdir, mx, my, tx, ty);
    if (s[6]) model_reload();
    else if (s[5] || s[0]) begin end
    else if (s[4]) begin
      mx = tx; my = ty;
      mb[ty*8+tx] = 0;
      if (mscore < 255) mscore++;
    end else if (s[3]) begin
      mx = tx; my = ty;
`ifdef RANDOM_GROWTH_EN
    end else if (s[2]) begin
      int c = int'(ml[5:0]);
      if (!is_wall(c % 8, c / 8) && c != my*8+mx && !mb[c]) mb[c] = 1;
`endif
    end else if (s[1]) mdir = d;
`ifdef RANDOM_GROWTH_EN
    ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
`endif
  endfunction

  function automatic snap_t snap(int d);
    snap_t e;
    e.hd  = (class_of(d) == 3) ? 3 : (class_of(d) == 2 ? 2 : 0);
    e.x   = mx;
    e.y   = my;
    e.sc  = mscore;
    e.cnt = beans_left();
    e.clr = (e.cnt == 0) ? 1 : 0;
    return e;
  endfunction

  // One cycle: drive at posedge+1, push the pre-edge snapshot.
  task automatic cyc(input logic [6:0] s, input logic [1:0] d,
                     input bit r);
    {first_do, game_over, eat_apple, null_out,
     random_growth, go_one_step, menu} = s;
    dir   = d;
    rst_n = r;
    if (!r) begin
      model_reload();
      ml = 8'hA5;
    end
    exp_q.push_back(snap(int'(d)));
    @(posedge clk2);
    if (r) model_edge(s, int'(d));
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int ex);
    checks++;
    if (act == ex) passes++;
    else $display("FAIL %s actual=%0d required=%0d t=%0t",
                  nm, act, ex, $time);
  endtask

  // Monitor: every cycle with a pending snapshot is compared.
  always @(negedge clk2) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      e = exp_q.pop_front();
      chk("head",     int'(head),     e.hd);
      chk("pos_x",    int'(pos_x),    e.x);
      chk("pos_y",    int'(pos_y),    e.y);
      chk("score",    int'(score),    e.sc);
      chk("bean_cnt", int'(bean_cnt), e.cnt);
      chk("clear",    int'(clear),    e.clr);
    end
  end

  function automatic int winner(logic [6:0] s);
    for (int b = 6; b >= 0; b--) if (s[b]) return b;
    return -1;
  endfunction

  // Drop eat/null strobes that would act on an illegal cell.
  function automatic logic [6:0] legalize(logic [6:0] s);
    logic [6:0] r = s;
    for (int k = 0; k < 7; k++) begin
      int w = winner(r);
      if (w == 4 && class_of(mdir) != 2) r[4] = 1'b0;
      else if (w == 3 && class_of(mdir) != 0) r[3] = 1'b0;
    end
    return r;
  endfunction

  initial begin
    logic [1:0] dh;
    model_reload();
    ml = 8'hA5;
    repeat (2) @(posedge clk2);
    #1;
    // reset state, start facing a bean
    cyc(S_NONE, 2'b00, 1'b0);
    cyc(S_NONE, 2'b00, 1'b1);
    // latch right, eat while looking left/up at walls
    cyc(S_STEP, 2'b00, 1'b1);
    cyc(S_EAT,  2'b01, 1'b1);
    cyc(S_NONE, 2'b10, 1'b1);
    cyc(S_NONE, 2'b01, 1'b1);
    cyc(S_NONE, 2'b10, 1'b1);
    // first_do beats eat_apple
    cyc(S_EAT | S_FD, 2'b00, 1'b1);
    cyc(S_GO_V | S_EAT, 2'b00, 1'b1);
    cyc(S_MENU, 2'b00, 1'b1);
    cyc(S_RG, 2'b11, 1'b1);
    // serpentine through all interior beans
    dh = 2'b00;
    for (int y = 1; y <= 6; y++) begin
      if (y > 1) begin
        cyc(S_STEP, 2'b11, 1'b1);
        cyc(S_EAT,  2'b11, 1'b1);
      end
      for (int k = 0; k < 5; k++) begin
        cyc(S_STEP, dh, 1'b1);
        cyc(S_EAT,  dh, 1'b1);
      end
      dh = (dh == 2'b00) ? 2'b01 : 2'b00;
    end
    cyc(S_NONE, 2'b10, 1'b1);
    cyc(S_FD,   2'b00, 1'b1);
    cyc(S_NONE, 2'b00, 1'b1);
    // reset pulse mid-move abandons the eat
    cyc(S_EAT,  2'b00, 1'b1);
    cyc(S_EAT,  2'b00, 1'b1);
    cyc(S_EAT,  2'b00, 1'b0);
    cyc(S_EAT,  2'b00, 1'b1);
    cyc(S_NONE, 2'b00, 1'b1);
    // randomized play
    for (int n = 0; n < 600; n++) begin
      logic [6:0] s = '0;
      logic [1:0] d = 2'($urandom);
      bit r = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 9) == 0) s = S_MENU;
      else begin
        for (int b = 1; b < 6; b++)
          s[b] = ($urandom_range(0, 2) == 0);
        s[6] = ($urandom_range(0, 59) == 0);
      end
      cyc(legalize(s), d, r);
    end
    cyc(S_NONE, 2'b00, 1'b1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk2);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
